bsg_manycore_io_mem_responder: RTL
==================================

# bsg_manycore_io_mem_responder

Endpoint that sits on the host side of one IO-row router's processor link and services remote store/load requests issued by array tiles toward the IO row. Requests arrive on the forward network as decomposed packet fields. The block executes them against a local byte-maskable word memory. It returns one reverse-network packet per request: a store acknowledgement/credit, or load data. A separate thin adapter packs and unpacks the manycore link struct.

## Interface
- addr_width_p, "inv": width of the network word address.
- data_width_p, 32: data word width; must be a multiple of 8.
- x_cord_width_p, "inv": x coordinate width.
- y_cord_width_p, "inv": y coordinate width.
- load_id_width_p, 5: width of the load ID tag.
- mem_els_p, 256: number of local memory words; must be a power of 2.
- fifo_els_p, 3: response FIFO depth; 3 is the minimum for 1 request/cycle throughput.

Ports:
- clk_i, in, 1: clock.
- reset_i, in, 1: asynchronous, active-high reset.
- fwd_v_i, in, 1: request valid.
- fwd_ready_o, out, 1: request accept.
- fwd_op_i, in, 2: 0 = load, 1 = store, 2/3 = reserved.
- fwd_mask_i, in, data_width_p/8: store byte enables.
- fwd_addr_i, in, addr_width_p: word address.
- fwd_data_i, in, data_width_p: store data.
- fwd_src_x_i, in, x_cord_width_p: requester x coordinate.
- fwd_src_y_i, in, y_cord_width_p: requester y coordinate.
- fwd_load_id_i, in, load_id_width_p: load tag.
- rev_v_o, out, 1: response valid.
- rev_ready_i, in, 1: response accept.
- rev_op_o, out, 1: 0 = store ack, 1 = load data.
- rev_data_o, out, data_width_p: load data; 0 for acks.
- rev_load_id_o, out, load_id_width_p: echoed fwd_load_id_i.
- rev_dst_x_o, out, x_cord_width_p: echoed fwd_src_x_i.
- rev_dst_y_o, out, y_cord_width_p: echoed fwd_src_y_i.
- err_count_o, out, 16: count of erroneous requests.

## Operation
- **Request handshake.** A request is transferred in a cycle where fwd_v_i & fwd_ready_o.
- **fwd_ready_o.** Equals (fifo_count + inflight) < fifo_els_p.
  - inflight is 1 when a request was accepted in the previous cycle.
  - fwd_ready_o does not depend on any fwd_* input.
- **Pipeline.**
  - Stage A (accept cycle): memory access is issued, and tag/src/op are registered.
  - Stage B: read data is available, and the response is pushed into the FIFO.
- **Address decode.** Index = fwd_addr_i[clog2(mem_els_p)-1:0]. The request is in range iff fwd_addr_i < mem_els_p.
- **Store, in range.** Writes only the bytes whose mask bit is set. Response: op 0, data 0.
- **Load, in range.** Response: op 1, data = memory word.
- **Out-of-range request.**
  - A store is dropped and still acked.
  - A load returns data 0 with op 1.
  - err_count_o increments.
- **Reserved op.** No memory access. Returns an ack (op 0), and err_count_o increments.
- **err_count_o.** Saturates at 16'hFFFF.
- **Response FIFO.**
  - Entries hold {op, data, load_id, dst_x, dst_y}.
  - The head drives rev_*, and rev_v_o = ~empty.
  - An entry pops when rev_v_o & rev_ready_i.
  - Enqueue and dequeue in the same cycle are allowed at any occupancy, including full.
- **Ordering.** Responses leave in strict request order. Every accepted request produces exactly one response.
- **Memory ordering.** Accesses are in request order: a load accepted the cycle after a store to the same index returns the new data.
- **Reset.** Asynchronous reset clears:
  - FIFO, so rev_v_o = 0 and rev_* fields = 0.
  - inflight = 0.
  - err_count_o = 0.
  - fwd_ready_o = 1 once reset is deasserted.

  Memory contents are not reset and are undefined. A request that is in flight when reset asserts is discarded, with no response.

## Timing
- **Latency.** A request accepted in cycle T produces rev_v_o = 1 in cycle T+2 at the earliest.
- **Throughput.** With rev_ready_i held high, one request is accepted and one response is issued every cycle.
- **Backpressure.** With rev_ready_i low, at most fifo_els_p requests are accepted. fwd_ready_o falls in the cycle after the count reaches the limit.
- **Recovery.** One pop frees one slot, so fwd_ready_o = 1 in the following cycle.
- **Response hold.** While rev_v_o = 1 and rev_ready_i = 0, all rev_* outputs hold stable.
- **Memory implementation.** Memory is single-port and synchronous-read: one access per cycle, write-first is not required.

## Test plan
- **Reset.** Assert reset_i mid-cycle with a request in flight -> rev_v_o = 0 immediately, err_count_o = 0, no response after release, fwd_ready_o = 1.
- **Masked store then load.**
  - Stimulus: store addr 5, data 32'hDEADBEEF, mask 4'b1111; then store addr 5, data 32'h00000011, mask 4'b0001; then load addr 5, id 7, src (2,3).
  - Response: ack, ack, then op 1, data 32'hDEADBE11, id 7, dst (2,3), in order.
- **Back-to-back streaming.** 100 alternating store/load requests with rev_ready_i = 1 -> fwd_ready_o stays 1, each response arrives 2 cycles after its request, data matches the reference model.
- **Backpressure.** Hold rev_ready_i = 0 and keep fwd_v_i = 1 -> exactly 3 requests accepted, fwd_ready_o = 0; pulse rev_ready_i for 1 cycle -> one more accepted, order preserved.
- **Errors.**
  - Load addr 256 with mem_els_p = 256 -> data 0, err_count_o = 1.
  - A reserved op 2 -> ack, err_count_o = 2.
  - Force the count to 16'hFFFF, then send one more error -> err_count_o stays 16'hFFFF.
- **Simultaneous enqueue and dequeue at full FIFO.** FIFO full, with rev_ready_i and an in-flight push in the same cycle -> no loss or duplication, count unchanged.

Source files
------------

// File: rtl/bsg_manycore_io_mem_responder.sv
// bsg_manycore_io_mem_responder
//
// Host-side endpoint on an IO-row router processor link. Executes remote
// load/store requests from array tiles against a local byte-maskable word
// memory and returns exactly one reverse-network response per request, in
// request order.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   fwd_v_i / fwd_ready_o   request handshake
//   fwd_op_i                0 load, 1 store, 2/3 reserved
//   fwd_mask_i              store byte enables
//   fwd_addr_i              word address
//   fwd_data_i              store data
//   fwd_src_x_i/_y_i        requester coordinates
//   fwd_load_id_i           load tag
//   rev_v_o / rev_ready_i   response handshake
//   rev_op_o                0 store ack, 1 load data
//   rev_data_o              load data (0 for acks)
//   rev_load_id_o           echoed load tag
//   rev_dst_x_o/_y_o        echoed requester coordinates
//   err_count_o             saturating count of erroneous requests
//
// Pipeline: stage A (accept cycle) issues the memory access and registers
// the tag; stage B pushes the response into a small FIFO. Request accept is
// throttled by FIFO occupancy plus the one possible in-flight request, so a
// stage-B push always has room.
module bsg_manycore_io_mem_responder #(
   parameter int unsigned addr_width_p    = 32,
   parameter int unsigned data_width_p    = 32,
   parameter int unsigned x_cord_width_p  = 4,
   parameter int unsigned y_cord_width_p  = 4,
   parameter int unsigned load_id_width_p = 5,
   parameter int unsigned mem_els_p       = 256,
   parameter int unsigned fifo_els_p      = 3
) (
   input  logic                         clk_i,
   input  logic                         reset_i,

   input  logic                         fwd_v_i,
   output logic                         fwd_ready_o,
   input  logic [1:0]                   fwd_op_i,
   input  logic [data_width_p/8-1:0]    fwd_mask_i,
   input  logic [addr_width_p-1:0]      fwd_addr_i,
   input  logic [data_width_p-1:0]      fwd_data_i,
   input  logic [x_cord_width_p-1:0]    fwd_src_x_i,
   input  logic [y_cord_width_p-1:0]    fwd_src_y_i,
   input  logic [load_id_width_p-1:0]   fwd_load_id_i,

   output logic                         rev_v_o,
   input  logic                         rev_ready_i,
   output logic                         rev_op_o,
   output logic [data_width_p-1:0]      rev_data_o,
   output logic [load_id_width_p-1:0]   rev_load_id_o,
   output logic [x_cord_width_p-1:0]    rev_dst_x_o,
   output logic [y_cord_width_p-1:0]    rev_dst_y_o,

   output logic [15:0]                  err_count_o
);

   localparam int unsigned mask_width_lp = data_width_p / 8;
   localparam int unsigned idx_width_lp  = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
   localparam int unsigned cnt_width_lp  = $clog2(fifo_els_p + 1);
   localparam int unsigned ptr_width_lp  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;

   localparam logic [addr_width_p:0] mem_els_addr_lp = (addr_width_p + 1)'(mem_els_p);
   localparam logic [cnt_width_lp:0] fifo_lim_lp     = (cnt_width_lp + 1)'(fifo_els_p);
   localparam logic [ptr_width_lp-1:0] ptr_last_lp   = ptr_width_lp'(fifo_els_p - 1);

   localparam logic [1:0] op_load_lp  = 2'd0;
   localparam logic [1:0] op_store_lp = 2'd1;

   typedef struct packed {
      logic                       op;
      logic [data_width_p-1:0]    data;
      logic [load_id_width_p-1:0] load_id;
      logic [x_cord_width_p-1:0]  dst_x;
      logic [y_cord_width_p-1:0]  dst_y;
   } rsp_t;

   // ---------------------------------------------------------------------
   // Stage A: accept, decode, memory access
   // ---------------------------------------------------------------------
   logic                    accept;
   logic                    in_range;
   logic                    is_load;
   logic                    is_store;
   logic                    mem_we;
   logic                    mem_re;
   logic                    req_err;
   logic [idx_width_lp-1:0] idx;

   assign accept   = fwd_v_i & fwd_ready_o;
   assign in_range = {1'b0, fwd_addr_i} < mem_els_addr_lp;
   assign is_load  = (fwd_op_i == op_load_lp);
   assign is_store = (fwd_op_i == op_store_lp);
   assign idx      = fwd_addr_i[idx_width_lp-1:0];
   assign mem_we   = accept & is_store & in_range;
   assign mem_re   = accept & is_load & in_range;
   // Out-of-range loads/stores and any reserved op count as errors.
   assign req_err  = accept & ~(in_range & (is_load | is_store));

   logic [data_width_p-1:0] mem_q [mem_els_p];
   logic [data_width_p-1:0] rd_data_q;

   // Single-port, synchronous read; contents intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < mask_width_lp; b++) begin
            if (fwd_mask_i[b]) begin
               mem_q[idx][8*b +: 8] <= fwd_data_i[8*b +: 8];
            end
         end
      end
      if (mem_re) begin
         rd_data_q <= mem_q[idx];
      end
   end

   // ---------------------------------------------------------------------
   // Stage B: registered request info, response formation
   // ---------------------------------------------------------------------
   logic                       inflight_q;
   logic                       b_op_q;
   logic                       b_hit_q;
   logic [load_id_width_p-1:0] b_load_id_q;
   logic [x_cord_width_p-1:0]  b_x_q;
   logic [y_cord_width_p-1:0]  b_y_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         inflight_q  <= 1'b0;
         b_op_q      <= 1'b0;
         b_hit_q     <= 1'b0;
         b_load_id_q <= '0;
         b_x_q       <= '0;
         b_y_q       <= '0;
      end else begin
         inflight_q <= accept;
         if (accept) begin
            b_op_q      <= is_load;
            b_hit_q     <= is_load & in_range;
            b_load_id_q <= fwd_load_id_i;
            b_x_q       <= fwd_src_x_i;
            b_y_q       <= fwd_src_y_i;
         end
      end
   end

   rsp_t push_entry;

   always_comb begin
      push_entry         = '0;
      push_entry.op      = b_op_q;
      push_entry.data    = b_hit_q ? rd_data_q : '0;
      push_entry.load_id = b_load_id_q;
      push_entry.dst_x   = b_x_q;
      push_entry.dst_y   = b_y_q;
   end

   // ---------------------------------------------------------------------
   // Response FIFO (circular, arbitrary depth)
   // ---------------------------------------------------------------------
   rsp_t                    fifo_mem_q [fifo_els_p];
   logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
   logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
   logic [cnt_width_lp-1:0] count_q, count_d;
   logic                    push;
   logic                    pop;
   rsp_t                    head;

   function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
      return (p == ptr_last_lp) ? '0 : p + ptr_width_lp'(1);
   endfunction

   assign push = inflight_q;
   assign pop  = rev_v_o & rev_ready_i;

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + cnt_width_lp'(1);
         2'b01:   count_d = count_q - cnt_width_lp'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; outputs are gated by valid instead.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= push_entry;
      end
   end

   assign rev_v_o = (count_q != '0);
   assign head    = rev_v_o ? fifo_mem_q[rd_ptr_q] : '0;

   assign rev_op_o      = head.op;
   assign rev_data_o    = head.data;
   assign rev_load_id_o = head.load_id;
   assign rev_dst_x_o   = head.dst_x;
   assign rev_dst_y_o   = head.dst_y;

   // Counting the in-flight request guarantees room for its stage-B push.
   assign fwd_ready_o = ((cnt_width_lp + 1)'(count_q) + (cnt_width_lp + 1)'(inflight_q))
                        < fifo_lim_lp;

   // ---------------------------------------------------------------------
   // Saturating error counter
   // ---------------------------------------------------------------------
   logic [15:0] err_count_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         err_count_q <= '0;
      end else if (req_err && (err_count_q != 16'hFFFF)) begin
         err_count_q <= err_count_q + 16'd1;
      end
   end

   assign err_count_o = err_count_q;

endmodule
